// File: rtl/rom_arbiter.sv
`timescale 1ns/1ps
// rom_arbiter: shares one boot-ROM TileLink slave between an instruction
// fetch requester (m0) and a debug/loader requester (m1). Only one Get is
// in flight at a time; a sticky watchdog flags a ROM that never answers.
//
// state | meaning
// IDLE  | no grant; pick a winner from the pending A requests
// FWD   | owner's A channel routed to the ROM until the A handshake
// WAIT  | ROM D channel routed back to the owner until the D handshake
module rom_arbiter #(
  parameter bit          FAIR     = 1'b1,
  parameter logic [15:0] WAIT_MAX = 16'd1024,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned SW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  // requester 0 (instruction fetch)
  input  logic          m0_a_valid_i,
  output logic          m0_a_ready_o,
  input  logic [2:0]    m0_a_opcode_i,
  input  logic [AW-1:0] m0_a_address_i,
  input  logic [2:0]    m0_a_size_i,
  input  logic [SW-1:0] m0_a_source_i,
  output logic          m0_d_valid_o,
  input  logic          m0_d_ready_i,
  output logic [2:0]    m0_d_opcode_o,
  output logic [DW-1:0] m0_d_data_o,
  output logic [SW-1:0] m0_d_source_o,

  // requester 1 (debug / loader)
  input  logic          m1_a_valid_i,
  output logic          m1_a_ready_o,
  input  logic [2:0]    m1_a_opcode_i,
  input  logic [AW-1:0] m1_a_address_i,
  input  logic [2:0]    m1_a_size_i,
  input  logic [SW-1:0] m1_a_source_i,
  output logic          m1_d_valid_o,
  input  logic          m1_d_ready_i,
  output logic [2:0]    m1_d_opcode_o,
  output logic [DW-1:0] m1_d_data_o,
  output logic [SW-1:0] m1_d_source_o,

  // downstream ROM slave
  output logic          bus_a_valid_o,
  input  logic          bus_a_ready_i,
  output logic [2:0]    bus_a_opcode_o,
  output logic [AW-1:0] bus_a_address_o,
  output logic [2:0]    bus_a_size_o,
  output logic [SW-1:0] bus_a_source_o,
  input  logic          bus_d_valid_i,
  output logic          bus_d_ready_o,
  input  logic [2:0]    bus_d_opcode_i,
  input  logic [DW-1:0] bus_d_data_i,
  input  logic [SW-1:0] bus_d_source_i,

  // status
  output logic          owner_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;
  logic [15:0] wcnt_q,  wcnt_d;
  logic        err_q,   err_d;

  logic          win;
  logic          own_a_valid;
  logic [2:0]    own_a_opcode;
  logic [AW-1:0] own_a_address;
  logic [2:0]    own_a_size;
  logic [SW-1:0] own_a_source;
  logic          own_d_ready;
  logic          a_fire;
  logic          d_fire;

  // Winner of the current arbitration (1 = m1); only meaningful in IDLE.
  always_comb begin
    win = 1'b0;
    if (FAIR) begin
      if (m0_a_valid_i && m1_a_valid_i) win = ~last_q;
      else                              win = m1_a_valid_i;
    end else begin
      win = ~m0_a_valid_i;
    end
  end

  // Select the granted requester's A fields and D-ready.
  always_comb begin
    own_a_valid   = m0_a_valid_i;
    own_a_opcode  = m0_a_opcode_i;
    own_a_address = m0_a_address_i;
    own_a_size    = m0_a_size_i;
    own_a_source  = m0_a_source_i;
    own_d_ready   = m0_d_ready_i;
    if (owner_q) begin
      own_a_valid   = m1_a_valid_i;
      own_a_opcode  = m1_a_opcode_i;
      own_a_address = m1_a_address_i;
      own_a_size    = m1_a_size_i;
      own_a_source  = m1_a_source_i;
      own_d_ready   = m1_d_ready_i;
    end
  end

  assign a_fire = (state_q == S_FWD)  && own_a_valid   && bus_a_ready_i;
  assign d_fire = (state_q == S_WAIT) && bus_d_valid_i && own_d_ready;

  // Next-state logic: grant, handshake tracking and the saturating watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_a_valid_i || m1_a_valid_i) begin
          owner_d = win;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        if (a_fire) begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_fire) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          if (wcnt_q != 16'hffff)           wcnt_d = wcnt_q + 16'd1;
          // The ROM keeps the slot; the flag only reports the stall.
          if (wcnt_q == WAIT_MAX - 16'd1)   err_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers; last starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Channel steering toward the ROM and back to the requesters.
  always_comb begin
    bus_a_valid_o   = 1'b0;
    bus_a_opcode_o  = own_a_opcode;
    bus_a_address_o = own_a_address;
    bus_a_size_o    = own_a_size;
    bus_a_source_o  = own_a_source;
    bus_d_ready_o   = 1'b0;
    m0_a_ready_o    = 1'b0;
    m1_a_ready_o    = 1'b0;
    m0_d_valid_o    = 1'b0;
    m1_d_valid_o    = 1'b0;
    if (state_q == S_FWD) begin
      bus_a_valid_o = own_a_valid;
      m0_a_ready_o  = ~owner_q & bus_a_ready_i;
      m1_a_ready_o  =  owner_q & bus_a_ready_i;
    end
    if (state_q == S_WAIT) begin
      bus_d_ready_o = own_d_ready;
      m0_d_valid_o  = ~owner_q & bus_d_valid_i;
      m1_d_valid_o  =  owner_q & bus_d_valid_i;
    end
  end

  // D payload is shared; each requester qualifies it with its own d_valid.
  assign m0_d_opcode_o = bus_d_opcode_i;
  assign m0_d_data_o   = bus_d_data_i;
  assign m0_d_source_o = bus_d_source_i;
  assign m1_d_opcode_o = bus_d_opcode_i;
  assign m1_d_data_o   = bus_d_data_i;
  assign m1_d_source_o = bus_d_source_i;

  assign owner_o = owner_q;
  assign busy_o  = (state_q != S_IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
`timescale 1ns/1ps
// Bench for rom_arbiter: a round-robin and a fixed-priority instance share
// stimulus; the one not under test is held in reset. Responses are checked
// by a scoreboard queue filled by the directed tests.
module tb_rom_arbiter;

  typedef struct packed {
    logic        m;
    logic [3:0]  src;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [2];
  logic sel;
  logic rst_cur;

  logic        m0_a_valid, m1_a_valid, m0_d_ready, m1_d_ready;
  logic [2:0]  m0_a_opcode, m1_a_opcode, m0_a_size, m1_a_size;
  logic [31:0] m0_a_address, m1_a_address;
  logic [3:0]  m0_a_source, m1_a_source;
  logic        bus_a_ready, bus_d_valid;
  logic [2:0]  bus_d_opcode;
  logic [63:0] bus_d_data;
  logic [3:0]  bus_d_source;

  logic        o_m0_a_ready [2], o_m1_a_ready [2], o_m0_d_valid [2], o_m1_d_valid [2];
  logic [2:0]  o_m0_d_opcode [2], o_m1_d_opcode [2];
  logic [63:0] o_m0_d_data [2], o_m1_d_data [2];
  logic [3:0]  o_m0_d_source [2], o_m1_d_source [2];
  logic        o_bus_a_valid [2], o_bus_d_ready [2];
  logic [2:0]  o_bus_a_opcode [2], o_bus_a_size [2];
  logic [31:0] o_bus_a_address [2];
  logic [3:0]  o_bus_a_source [2];
  logic        o_owner [2], o_busy [2], o_err [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rom_arbiter #(.FAIR(g == 0 ? 1'b1 : 1'b0), .WAIT_MAX(16'd8)) dut (
      .clk(clk), .rst_n(rst_v[g]),
      .m0_a_valid_i(m0_a_valid), .m0_a_ready_o(o_m0_a_ready[g]),
      .m0_a_opcode_i(m0_a_opcode), .m0_a_address_i(m0_a_address),
      .m0_a_size_i(m0_a_size), .m0_a_source_i(m0_a_source),
      .m0_d_valid_o(o_m0_d_valid[g]), .m0_d_ready_i(m0_d_ready),
      .m0_d_opcode_o(o_m0_d_opcode[g]), .m0_d_data_o(o_m0_d_data[g]),
      .m0_d_source_o(o_m0_d_source[g]),
      .m1_a_valid_i(m1_a_valid), .m1_a_ready_o(o_m1_a_ready[g]),
      .m1_a_opcode_i(m1_a_opcode), .m1_a_address_i(m1_a_address),
      .m1_a_size_i(m1_a_size), .m1_a_source_i(m1_a_source),
      .m1_d_valid_o(o_m1_d_valid[g]), .m1_d_ready_i(m1_d_ready),
      .m1_d_opcode_o(o_m1_d_opcode[g]), .m1_d_data_o(o_m1_d_data[g]),
      .m1_d_source_o(o_m1_d_source[g]),
      .bus_a_valid_o(o_bus_a_valid[g]), .bus_a_ready_i(bus_a_ready),
      .bus_a_opcode_o(o_bus_a_opcode[g]), .bus_a_address_o(o_bus_a_address[g]),
      .bus_a_size_o(o_bus_a_size[g]), .bus_a_source_o(o_bus_a_source[g]),
      .bus_d_valid_i(bus_d_valid), .bus_d_ready_o(o_bus_d_ready[g]),
      .bus_d_opcode_i(bus_d_opcode), .bus_d_data_i(bus_d_data),
      .bus_d_source_i(bus_d_source),
      .owner_o(o_owner[g]), .busy_o(o_busy[g]), .err_o(o_err[g])
    );
  end

  wire        m0_a_ready    = o_m0_a_ready[sel];
  wire        m1_a_ready    = o_m1_a_ready[sel];
  wire        m0_d_valid    = o_m0_d_valid[sel];
  wire        m1_d_valid    = o_m1_d_valid[sel];
  wire [63:0] m0_d_data     = o_m0_d_data[sel];
  wire [63:0] m1_d_data     = o_m1_d_data[sel];
  wire [3:0]  m0_d_source   = o_m0_d_source[sel];
  wire [3:0]  m1_d_source   = o_m1_d_source[sel];
  wire        bus_a_valid   = o_bus_a_valid[sel];
  wire [31:0] bus_a_address = o_bus_a_address[sel];
  wire [3:0]  bus_a_source  = o_bus_a_source[sel];
  wire        bus_d_ready   = o_bus_d_ready[sel];
  wire        owner         = o_owner[sel];
  wire        busy          = o_busy[sel];
  wire        err           = o_err[sel];
  assign rst_cur = rst_v[sel];

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q [$];
  logic [31:0] addr_q0 [$];
  logic [31:0] addr_q1 [$];
  int   rom_lat;
  bit   rom_mute;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rom_data(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 64'h000015b7f1402573;
      32'h0000_2000: return 64'hb303638d1005859b;
      default:       return {a, ~a};
    endcase
  endfunction

  // ROM model: accepts every A beat, answers after rom_lat idle WAIT cycles.
  bit          rom_hs_a, rom_hs_d, rom_pend;
  int          rom_cnt;
  logic [31:0] rom_addr;
  logic [3:0]  rom_src;
  initial begin
    bus_a_ready = 1'b1; bus_d_valid = 1'b0; bus_d_opcode = 3'd1;
    bus_d_data = '0; bus_d_source = '0; rom_pend = 0; rom_cnt = 0;
    rom_addr = '0; rom_src = '0;
    forever begin
      @(negedge clk);
      rom_hs_a = bus_a_valid && bus_a_ready;
      rom_hs_d = bus_d_valid && bus_d_ready;
      if (rom_hs_a) begin rom_addr = bus_a_address; rom_src = bus_a_source; end
      @(posedge clk); #1;
      if (!rst_cur) begin
        rom_pend = 0; bus_d_valid = 1'b0;
      end else begin
        if (rom_hs_d) bus_d_valid = 1'b0;
        if (rom_hs_a && !rom_mute) begin rom_pend = 1; rom_cnt = rom_lat; end
        else if (rom_pend && rom_cnt > 0) rom_cnt--;
        if (rom_pend && rom_cnt == 0) begin
          bus_d_valid = 1'b1; bus_d_data = rom_data(rom_addr);
          bus_d_source = rom_src; rom_pend = 0;
        end
      end
    end
  end

  // Requester models: present queued Get addresses, hold until accepted.
  bit drv_hs0, drv_hs1;
  initial begin
    m0_a_valid = 0; m0_a_opcode = 3'd4; m0_a_size = 3'd3; m0_a_source = 4'h3; m0_a_address = '0;
    m1_a_valid = 0; m1_a_opcode = 3'd4; m1_a_size = 3'd3; m1_a_source = 4'h5; m1_a_address = '0;
    forever begin
      @(negedge clk);
      drv_hs0 = m0_a_valid && m0_a_ready;
      drv_hs1 = m1_a_valid && m1_a_ready;
      @(posedge clk); #1;
      if (drv_hs0 && addr_q0.size() > 0) void'(addr_q0.pop_front());
      if (drv_hs1 && addr_q1.size() > 0) void'(addr_q1.pop_front());
      m0_a_valid = (addr_q0.size() > 0);
      if (addr_q0.size() > 0) m0_a_address = addr_q0[0];
      m1_a_valid = (addr_q1.size() > 0);
      if (addr_q1.size() > 0) m1_a_address = addr_q1[0];
    end
  end

  task automatic pop_compare(input logic m, input logic [63:0] data, input logic [3:0] src);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_resp: got response on m%0d data %0h, expected none", m, data);
    end else begin
      e = exp_q.pop_front();
      check("resp_master", 64'(m), 64'(e.m));
      check("resp_data", data, e.data);
      check("resp_source", 64'(src), 64'(e.src));
    end
  endtask

  // Monitor: compares every delivered D beat against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_cur) begin
        if (m0_d_valid || m1_d_valid)
          check("single_d_valid", 64'(m0_d_valid & m1_d_valid), 64'd0);
        if (m0_d_valid && m0_d_ready) pop_compare(1'b0, m0_d_data, m0_d_source);
        if (m1_d_valid && m1_d_ready) pop_compare(1'b1, m1_d_data, m1_d_source);
        if (!busy)
          check("idle_quiet", 64'({m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid,
                                   bus_a_valid, bus_d_ready}), 64'd0);
      end
    end
  end

  task automatic check_reset(input string name);
    check(name, 64'({owner, busy, err, bus_a_valid, bus_d_ready, m0_a_ready,
                     m1_a_ready, m0_d_valid, m1_d_valid}), 64'd0);
  endtask

  task automatic pulse_reset(input int idx);
    @(negedge clk); rst_v[idx] = 1'b0;
    repeat (2) @(negedge clk);
    rst_v[idx] = 1'b1;
  endtask

  task automatic drain(input string name, output int busy_cycles, output bit m1_dv);
    bit done;
    done = 0; busy_cycles = 0; m1_dv = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk); #1;
      if (busy) busy_cycles++;
      if (m1_d_valid) m1_dv = 1;
      if (exp_q.size() == 0 && !busy && !m0_a_valid && !m1_a_valid) done = 1;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic push_exp(input logic m, input logic [63:0] data);
    exp_t e;
    e.m = m; e.src = m ? 4'h5 : 4'h3; e.data = data;
    exp_q.push_back(e);
  endtask

  int bc;
  bit flag, seen;

  initial begin
    sel = 1'b0; rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    rom_lat = 0; rom_mute = 0; m0_d_ready = 1; m1_d_ready = 1;
    #2 rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    #1 check_reset("reset_rr");
    sel = 1'b1;
    #1 check_reset("reset_fp");
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_v[0] = 1'b1;

    // 1: lone m0 Get, ROM answers after 3 cycles
    rom_lat = 3;
    push_exp(1'b0, 64'h000015b7f1402573);
    addr_q0.push_back(32'h1000);
    drain("t1", bc, flag);
    check("t1_busy_cycles", 64'(bc), 64'd5);
    check("t1_m1_d_valid", 64'(flag), 64'd0);

    // 2: round-robin with both requesting continuously
    pulse_reset(0);
    rom_lat = 1;
    push_exp(1'b0, 64'h000015b7f1402573);
    push_exp(1'b1, 64'hb303638d1005859b);
    push_exp(1'b0, 64'h00001008ffffeff7);
    push_exp(1'b1, 64'h00002008ffffdff7);
    addr_q0.push_back(32'h1000); addr_q0.push_back(32'h1008);
    addr_q1.push_back(32'h2000); addr_q1.push_back(32'h2008);
    drain("t2", bc, flag);

    // 3: fixed priority, m0 keeps requesting
    sel = 1'b1; rst_v[0] = 1'b0;
    pulse_reset(1);
    rom_lat = 0;
    push_exp(1'b0, 64'h000015b7f1402573);
    push_exp(1'b0, 64'h00001008ffffeff7);
    push_exp(1'b0, 64'h00001010ffffefef);
    push_exp(1'b0, 64'h00001018ffffefe7);
    push_exp(1'b1, 64'hb303638d1005859b);
    addr_q0.push_back(32'h1000); addr_q0.push_back(32'h1008);
    addr_q0.push_back(32'h1010); addr_q0.push_back(32'h1018);
    addr_q1.push_back(32'h2000);
    flag = 0;
    for (int c = 0; c < 300 && exp_q.size() > 1; c++) begin
      @(negedge clk); #1;
      if (m1_a_ready) flag = 1;
    end
    check("t3_m1_a_ready", 64'(flag), 64'd0);
    check("t3_m0_served", 64'(exp_q.size()), 64'd1);
    drain("t3", bc, flag);

    // 4: owner stalls d_ready for 5 cycles
    sel = 1'b0; rst_v[1] = 1'b0;
    pulse_reset(0);
    rom_lat = 0; m0_d_ready = 0;
    push_exp(1'b0, 64'h000015b7f1402573);
    addr_q0.push_back(32'h1000);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_d_valid && busy) seen = 1;
    end
    check("t4_resp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_busy", 64'(busy), 64'd1);
      check("t4_stall_bus_d_ready", 64'(bus_d_ready), 64'd0);
      check("t4_stall_m0_d_valid", 64'(m0_d_valid), 64'd1);
      if (i < 4) @(negedge clk);
    end
    #1 check("t4_not_delivered", 64'(exp_q.size()), 64'd1);
    @(posedge clk); #1 m0_d_ready = 1;
    @(negedge clk); #1;
    check("t4_delivered", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("t4_idle_after", 64'(busy), 64'd0);

    // 5: ROM never answers, watchdog with WAIT_MAX=8
    pulse_reset(0);
    rom_mute = 1;
    addr_q0.push_back(32'h1000);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_a_valid && bus_a_ready) seen = 1;
    end
    check("t5_a_handshake", 64'(seen), 64'd1);
    flag = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (err) flag = 1;
    end
    check("t5_err_early", 64'(flag), 64'd0);
    @(negedge clk);
    check("t5_err_at_8", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 64'(err), 64'd1);
    check("t5_still_wait", 64'(busy), 64'd1);
    @(posedge clk); #3 rst_v[0] = 1'b0;
    addr_q0.delete();
    #1 check("t5_err_cleared", 64'(err), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    rom_mute = 0;

    // 6: async reset in WAIT, then m0 preferred on the next tie
    rom_mute = 1;
    addr_q1.push_back(32'h2000);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_d_ready) seen = 1;
    end
    check("t6_in_wait", 64'(seen), 64'd1);
    check("t6_owner_m1", 64'(owner), 64'd1);
    @(posedge clk); #3 rst_v[0] = 1'b0;
    addr_q1.delete();
    #1 check_reset("t6_async_reset");
    rom_mute = 0;
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    rom_lat = 1;
    push_exp(1'b0, 64'h00001008ffffeff7);
    push_exp(1'b1, 64'hb303638d1005859b);
    addr_q0.push_back(32'h1008);
    addr_q1.push_back(32'h2000);
    drain("t6", bc, flag);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
